adc_sample_filter: RTL and testbench

ADC_SAMPLE_FILTER -- requirements
Module: adc_sample_filter

---
 rtl/adc_pkg.sv | 14 +
 rtl/adc_sample_ring.sv | 49 ++++
 rtl/adc_sample_filter.sv | 109 ++++++++++
 tb/tb_adc_sample_filter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the ADC moving-average filter.
package adc_pkg;

    localparam int unsigned ADC_W = 8;
    localparam int unsigned AVG_LOG2_DEFAULT = 3;
    localparam logic [ADC_W-1:0] THRESH_HI_DEFAULT = 8'd192;
    localparam logic [ADC_W-1:0] THRESH_LO_DEFAULT = 8'd64;

    typedef enum logic {
        StFill = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/adc_sample_ring.sv
// N-entry sample window: writes at the pointer and exposes the slot about to be overwritten.
module adc_sample_ring
    import adc_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [ADC_W-1:0] wr_data,
    output logic [ADC_W-1:0] oldest
);

    localparam int unsigned N = 1 << AVG_LOG2;

    logic [ADC_W-1:0]    mem_q [N];
    logic [ADC_W-1:0]    mem_d [N];
    logic [AVG_LOG2-1:0] ptr_q;
    logic [AVG_LOG2-1:0] ptr_d;

    // The slot under the write pointer holds the oldest sample once the window is full.
    assign oldest = mem_q[ptr_q];

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (wr_en) begin
            mem_d[ptr_q] = wr_data;
            ptr_d        = ptr_q + AVG_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is not reset; the top masks unwritten slots while filling.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/adc_sample_filter.sv
// Moving-average filter over the last 2**AVG_LOG2 ADC samples with a hysteresis alarm.
module adc_sample_filter
    import adc_pkg::*;
#(
    parameter int unsigned      AVG_LOG2  = AVG_LOG2_DEFAULT,
    parameter logic [ADC_W-1:0] THRESH_HI = THRESH_HI_DEFAULT,
    parameter logic [ADC_W-1:0] THRESH_LO = THRESH_LO_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADC_W-1:0]    sample_in,
    input  logic                sample_valid,
    input  logic                clear,
    output logic [ADC_W-1:0]    avg_out,
    output logic                avg_valid,
    output logic                alarm,
    output logic [AVG_LOG2:0]   fill_count
);

    localparam int unsigned N      = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = ADC_W + AVG_LOG2;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;

    state_e             state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [ADC_W-1:0]   avg_out_q, avg_out_d;
    logic               avg_valid_q, avg_valid_d;
    logic               alarm_q, alarm_d;

    logic [ADC_W-1:0]   oldest;
    logic [ADC_W-1:0]   oldest_term;
    logic [SUM_W-1:0]   sum_upd;
    logic [ADC_W-1:0]   avg_new;

    adc_sample_ring #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (sample_valid & ~clear),
        .wr_data (sample_in),
        .oldest  (oldest)
    );

    always_comb begin
        oldest_term = (state_q == StRun) ? oldest : '0;
        sum_upd     = sum_q + SUM_W'(sample_in) - SUM_W'(oldest_term);
        avg_new     = sum_upd[SUM_W-1:AVG_LOG2];

        state_d     = state_q;
        fill_d      = fill_q;
        sum_d       = sum_q;
        avg_out_d   = avg_out_q;
        avg_valid_d = 1'b0;
        alarm_d     = alarm_q;

        if (clear) begin
            state_d = StFill;
            fill_d  = '0;
            sum_d   = '0;
            alarm_d = 1'b0;
        end else if (sample_valid) begin
            sum_d = sum_upd;
            if (state_q == StRun) begin
                avg_valid_d = 1'b1;
            end else begin
                fill_d = fill_q + FILL_W'(1);
                if (fill_q == FILL_W'(N - 1)) begin
                    state_d     = StRun;
                    avg_valid_d = 1'b1;
                end
            end
            if (avg_valid_d) begin
                avg_out_d = avg_new;
                if (avg_new >= THRESH_HI) begin
                    alarm_d = 1'b1;
                end else if (avg_new <= THRESH_LO) begin
                    alarm_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StFill;
            fill_q      <= '0;
            sum_q       <= '0;
            avg_out_q   <= '0;
            avg_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            sum_q       <= sum_d;
            avg_out_q   <= avg_out_d;
            avg_valid_q <= avg_valid_d;
            alarm_q     <= alarm_d;
        end
    end

    assign avg_out    = avg_out_q;
    assign avg_valid  = avg_valid_q;
    assign alarm      = alarm_q;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_adc_sample_filter.sv
// Directed bench for adc_sample_filter: fill, run, truncation, hysteresis, clear and reset.
module tb_adc_sample_filter;

    logic       clk;
    logic       reset;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       clear;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic       alarm;
    logic [3:0] fill_count;

    int checks = 0;
    int errors = 0;
    int valid_seen;

    adc_sample_filter dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear        (clear),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .alarm        (alarm),
        .fill_count   (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample registered outputs just after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic clr);
        @(negedge clk);
        sample_valid = v;
        sample_in    = d;
        clear        = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        @(negedge clk);
        reset        = 1'b0;
        sample_valid = v;
        sample_in    = 8'd99;
        clear        = v;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset        = 1'b1;
        sample_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic feed_count(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, d, 1'b0);
            if (avg_valid) valid_seen++;
        end
    endtask

    logic [7:0] ramp_up [8];
    logic [7:0] ramp_dn [8];
    logic       alarm_dn [8];

    initial begin
        ramp_up  = '{8'd31, 8'd63, 8'd95, 8'd127, 8'd159, 8'd191, 8'd223, 8'd255};
        ramp_dn  = '{8'd223, 8'd191, 8'd159, 8'd127, 8'd95, 8'd63, 8'd31, 8'd0};
        alarm_dn = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        reset        = 1'b0;
        sample_in    = 8'd0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_avg_out", avg_out, 0);
        check("rst_avg_valid", avg_valid, 0);
        check("rst_alarm", alarm, 0);
        check("rst_fill", fill_count, 0);
        @(negedge clk);
        reset = 1'b1;

        // Fill with 100s
        valid_seen = 0;
        feed_count(8'd100, 7);
        check("fill7_no_valid", valid_seen, 0);
        check("fill7_count", fill_count, 7);
        step(1'b1, 8'd100, 1'b0);
        check("fill8_valid", avg_valid, 1);
        check("fill8_avg", avg_out, 100);
        check("fill8_count", fill_count, 8);
        step(1'b0, 8'd7, 1'b0);
        check("idle_valid", avg_valid, 0);
        check("idle_hold", avg_out, 100);
        check("idle_count", fill_count, 8);

        // Flush to zeros, then back-to-back 255s
        feed_count(8'd0, 8);
        check("zeros_avg", avg_out, 0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'd255, 1'b0);
            check($sformatf("up%0d_valid", k), avg_valid, 1);
            check($sformatf("up%0d_avg", k), avg_out, ramp_up[k]);
            check($sformatf("up%0d_alarm", k), alarm, (k >= 6) ? 1 : 0);
        end

        // Hysteresis on the way down
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'd0, 1'b0);
            check($sformatf("dn%0d_avg", k), avg_out, ramp_dn[k]);
            check($sformatf("dn%0d_alarm", k), alarm, alarm_dn[k]);
        end

        // Truncation
        step(1'b1, 8'd1, 1'b0);
        feed_count(8'd0, 7);
        check("trunc_avg0", avg_out, 0);
        feed_count(8'd7, 7);
        step(1'b1, 8'd3, 1'b0);
        check("trunc_avg6", avg_out, 6);
        check("trunc_valid", avg_valid, 1);

        // Clear with simultaneous sample while alarm is set
        feed_count(8'd255, 8);
        check("pre_clear_alarm", alarm, 1);
        step(1'b1, 8'd77, 1'b1);
        check("clear_fill", fill_count, 0);
        check("clear_alarm", alarm, 0);
        check("clear_valid", avg_valid, 0);
        check("clear_hold_avg", avg_out, 255);
        valid_seen = 0;
        feed_count(8'd10, 7);
        check("post_clear_no_valid", valid_seen, 0);
        check("post_clear_fill7", fill_count, 7);
        step(1'b1, 8'd10, 1'b0);
        check("post_clear_avg", avg_out, 10);
        check("post_clear_valid", avg_valid, 1);

        // Exact threshold boundaries
        feed_count(8'd192, 7);
        check("hi7_alarm", alarm, 0);
        step(1'b1, 8'd192, 1'b0);
        check("hi8_avg", avg_out, 192);
        check("hi8_alarm", alarm, 1);
        feed_count(8'd64, 7);
        check("lo7_avg", avg_out, 80);
        check("lo7_alarm", alarm, 1);
        step(1'b1, 8'd64, 1'b0);
        check("lo8_avg", avg_out, 64);
        check("lo8_alarm", alarm, 0);

        // Reset mid-window, with sample_valid and clear also high
        feed_count(8'd200, 8);
        check("pre_rst_alarm", alarm, 1);
        do_reset(1'b0);
        feed_count(8'd200, 5);
        check("mid_fill5", fill_count, 5);
        do_reset(1'b1);
        check("mid_rst_avg", avg_out, 0);
        check("mid_rst_valid", avg_valid, 0);
        check("mid_rst_alarm", alarm, 0);
        check("mid_rst_fill", fill_count, 0);
        valid_seen = 0;
        feed_count(8'd50, 7);
        check("rst50_no_valid", valid_seen, 0);
        step(1'b1, 8'd50, 1'b0);
        check("rst50_avg", avg_out, 50);
        check("rst50_valid", avg_valid, 1);
        check("rst50_fill", fill_count, 8);
        step(1'b0, 8'd0, 1'b0);
        check("rst50_idle_valid", avg_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
